// File: rtl/filter_bank_ws.sv
// Weight source for the weight-stationary PE array: a writable weight store streamed one element per lane per beat.
// Optional build macro FB_ZERO_LANES_EN: lanes at or above P load zero each beat and lane_mask_o reflects P.
module filter_bank_ws #(
  parameter int DW    = 16,
  parameter int NCOL  = 14,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [DW-1:0]      wr_data_i,
  input  logic               start_i,
  input  logic [3:0]         cfg_r_i,
  input  logic [3:0]         cfg_s_i,
  input  logic [3:0]         cfg_p_i,
  input  logic [3:0]         cfg_q_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [NCOL*DW-1:0] out_data_o,
  output logic [NCOL-1:0]    lane_mask_o,
  output logic               pass_done_o,
  output logic               cfg_err_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state_o
);

  localparam int ADW = AW + 8;
  localparam logic [4:0] NCOL_L = 5'(NCOL);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_e;

  // Handshake: a beat transfers on a rising clk edge where out_valid_o && out_ready_i;
  // out_data_o is held stable whenever out_valid_o is high and out_ready_i is low.
  state_e state_q, state_d;

  logic [DW-1:0]      mem_q [DEPTH];
  logic [7:0]         fs_q, elem_q, elem_nxt;
  logic [3:0]         cpp_q, p_q, ch_q, ch_nxt;
  logic [NCOL*DW-1:0] out_data_q, out_data_d;
  logic               pass_done_q, cfg_err_q;
  logic [7:0]         fs_new;
  logic [3:0]         cpp_new;
  logic               cfg_bad, start_ok, hs, last_elem, last_beat, cap;
  logic [AW-1:0]      rd_addr [NCOL];
  logic [ADW-1:0]     ch_off;

  assign fs_new   = {4'b0, cfg_r_i} * {4'b0, cfg_s_i};
  assign cfg_bad  = (fs_new == 8'd0) || (cfg_p_i == 4'd0) || ({1'b0, cfg_p_i} > NCOL_L);
  // fs == 0 is illegal anyway; the guard only keeps the divider away from zero.
  assign cpp_new  = ((fs_new > {4'b0, cfg_q_i}) || (fs_new == 8'd0)) ? 4'd1
                  : 4'({4'b0, cfg_q_i} / fs_new);
  assign start_ok = (state_q == S_IDLE) && start_i && !cfg_bad;

  assign hs        = (state_q == S_RUN) && out_ready_i;
  assign last_elem = (elem_q == fs_q - 8'd1);
  assign last_beat = last_elem && (ch_q == cpp_q - 4'd1);
  assign cap       = (state_q == S_LOAD) || (hs && !last_beat);

  always_comb begin
    elem_nxt = 8'd0;
    ch_nxt   = 4'd0;
    if (state_q == S_RUN) begin
      elem_nxt = last_elem ? 8'd0 : elem_q + 8'd1;
      ch_nxt   = last_elem ? ch_q + 4'd1 : ch_q;
    end
  end

  // Addresses are formed wide and then truncated, so they wrap around the store.
  assign ch_off = ADW'(ch_nxt) * ADW'(p_q) * ADW'(fs_q);

  always_comb begin
    for (int i = 0; i < NCOL; i++) begin
      rd_addr[i] = AW'(ch_off + ADW'(i) * ADW'(fs_q) + ADW'(elem_nxt));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_comb begin
    out_data_d = out_data_q;
    if (cap) begin
      for (int i = 0; i < NCOL; i++) begin
        if (5'(i) < {1'b0, p_q}) out_data_d[i*DW +: DW] = mem_q[rd_addr[i]];
`ifdef FB_ZERO_LANES_EN
        else out_data_d[i*DW +: DW] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (hs && last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q == S_RUN);
    busy_o      = (state_q != S_IDLE);
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_q        <= '0;
      cpp_q       <= '0;
      p_q         <= '0;
      elem_q      <= '0;
      ch_q        <= '0;
      out_data_q  <= '0;
      pass_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      pass_done_q <= hs && last_beat;
      if (start_ok) begin
        fs_q  <= fs_new;
        cpp_q <= cpp_new;
        p_q   <= cfg_p_i;
      end
      if ((state_q == S_IDLE) && start_i) cfg_err_q <= cfg_bad;
      if (cap) begin
        elem_q <= elem_nxt;
        ch_q   <= ch_nxt;
      end
    end
  end

`ifdef FB_ZERO_LANES_EN
  logic [NCOL-1:0] lane_mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_mask_q <= '0;
    end else if (state_q == S_LOAD) begin
      for (int i = 0; i < NCOL; i++) lane_mask_q[i] <= (5'(i) < {1'b0, p_q});
    end
  end

  assign lane_mask_o = lane_mask_q;
`else
  assign lane_mask_o = '1;
`endif

  assign out_data_o  = out_data_q;
  assign pass_done_o = pass_done_q;
  assign cfg_err_o   = cfg_err_q;

endmodule
